serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and difference width in bits; SHALL be at least 2.
REQ-002 Parameter DIGIT, default 1, bits processed per cycle; SHALL divide WIDTH exactly, giving N = WIDTH/DIGIT processing cycles.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request; sampled on a rising clk edge when accepted.
REQ-007 A  input  WIDTH  minuend; sampled on the same edge as start.
REQ-008 B  input  WIDTH  subtrahend; sampled on the same edge as start.
REQ-009 D  output  WIDTH  difference A-B mod 2^WIDTH; registered.
REQ-010 Bo  output  1  final borrow out, equal to 1 iff A < B unsigned; registered.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse when D/Bo become valid.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE -> RUN on start=1; A and B are captured, digit index k=0, borrow=0.
REQ-015 RUN SHALL process digit k (bits k*DIGIT .. k*DIGIT+DIGIT-1) per cycle, LSB digit first, using the running borrow; k increments each cycle.
REQ-016 Each bit SHALL use d = a ^ b ^ bin and bout = (~a & b) | (~(a ^ b) & bin), chained within a digit.
REQ-017 RUN -> DONE after digit N-1 is processed; D and Bo are updated on that edge.
REQ-018 DONE SHALL last exactly one cycle with done=1; it then goes to RUN if start=1, otherwise to IDLE.
REQ-019 Timing: start sampled at edge t -> busy=1 for cycles t+1..t+N; done=1 in cycle t+N+1 only.
REQ-020 start while in RUN SHALL be ignored; operands and progress are unaffected.
REQ-021 start in the DONE cycle SHALL be accepted, giving back-to-back operation with no IDLE gap.
REQ-022 D and Bo SHALL hold their last result until the next result is written; they SHALL NOT show partial values during RUN.
REQ-023 A and B may change freely after the capture edge without affecting the result.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, D=0, Bo=0, busy=0, done=0, k=0, internal borrow=0.
REQ-025 Reset during RUN SHALL abort the operation; no done pulse follows.
REQ-026 After rst_n deasserts, the first start on a clk edge SHALL be accepted normally.

Configuration
REQ-027 Macro SERIAL_SUB_SAT_EN: when defined, a result with final borrow 1 SHALL write D=0, with Bo still 1.
REQ-028 Without SERIAL_SUB_SAT_EN, D SHALL always be the wrap-around difference mod 2^WIDTH.

Verification
REQ-029 WIDTH=8, DIGIT=1: A=0x5A, B=0x3C, start pulse -> busy high 8 cycles, done in cycle 9, D=0x1E, Bo=0.
REQ-030 A=0x00, B=0x01 -> D=0xFF, Bo=1; with SERIAL_SUB_SAT_EN -> D=0x00, Bo=1.
REQ-031 A=0xFF, B=0xFF, then start=1 in the DONE cycle with A=0x10, B=0x20 -> first result D=0x00, Bo=0; second result D=0xF0, Bo=1 with no idle cycle between.
REQ-032 start pulsed again at cycle 3 of RUN with different operands -> ignored; result matches the first operands.
REQ-033 rst_n low at cycle 4 of RUN -> all outputs 0 immediately, no done; a following start completes correctly.
REQ-034 WIDTH=8, DIGIT=4: A=0x80, B=0x01 -> busy 2 cycles, done in cycle 3, D=0x7F, Bo=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial A-B, DIGIT bits per cycle, LSB digit first, registered D/Bo
//   clk, rst_n (async active-low), start/A/B request, D/Bo result, busy while running, done pulse.
//   SERIAL_SUB_SAT_EN: when defined, a borrowing result writes D=0 (Bo stays 1).
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             busy,
  output logic             done
);
  localparam int N  = WIDTH / DIGIT;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_n;
  logic [KW-1:0]    k;
  logic             borrow, bw;
  logic [DIGIT-1:0] da, db, dd;
  // ripple the borrow through the current digit; acc_n is the partial difference including it
  always_comb begin
    da = a_r[int'(k)*DIGIT +: DIGIT];
    db = b_r[int'(k)*DIGIT +: DIGIT];
    bw = borrow;
    dd = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dd[i] = da[i] ^ db[i] ^ bw;
      bw    = (~da[i] & db[i]) | (~(da[i] ^ db[i]) & bw);
    end
    acc_n = acc;
    acc_n[int'(k)*DIGIT +: DIGIT] = dd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      k      <= '0;
      borrow <= 1'b0;
      D      <= '0;
      Bo     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            a_r    <= A;
            b_r    <= B;
            k      <= '0;
            borrow <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_n;
          borrow <= bw;
          k      <= k + KW'(1);
          if (k == KW'(N - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            k     <= '0;
            Bo    <= bw;
`ifdef SERIAL_SUB_SAT_EN
            D     <= bw ? '0 : acc_n;
`else
            D     <= acc_n;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       s1 = 1'b0, s4 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0, d1, d4;
  logic       bo1, busy1, done1, bo4, busy4, done4;
  int tests = 0, fails = 0;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .start(s1), .A(a1), .B(b1),
    .D(d1), .Bo(bo1), .busy(busy1), .done(done1));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .start(s4), .A(a4), .B(b4),
    .D(d4), .Bo(bo4), .busy(busy4), .done(done4));

  function automatic logic [7:0] exp_d(input logic [7:0] a, input logic [7:0] b);
`ifdef SERIAL_SUB_SAT_EN
    return (a < b) ? 8'h00 : 8'(a - b);
`else
    return 8'(a - b);
`endif
  endfunction

  // one transaction; reports cycles with busy, cycle index of done (-1 if none) and whether D held
  task automatic do_op(input bit sel, input logic [7:0] a, input logic [7:0] b, output logic [7:0] d,
                       output logic bo, output int busy_cnt, output int done_cyc, output bit held);
    logic [7:0] d0;
    @(negedge clk);
    if (sel) begin s4 = 1'b1; a4 = a; b4 = b; end
    else begin s1 = 1'b1; a1 = a; b1 = b; end
    @(negedge clk);
    s1 = 1'b0; s4 = 1'b0;
    a1 = 8'($urandom); b1 = 8'($urandom); a4 = 8'($urandom); b4 = 8'($urandom);
    busy_cnt = 0; done_cyc = -1; held = 1'b1; d = '0; bo = 1'b0;
    d0 = sel ? d4 : d1;
    for (int c = 1; c <= 30; c++) begin
      if (sel ? busy4 : busy1) busy_cnt++;
      if ((sel ? done4 : done1)) begin
        done_cyc = c; d = sel ? d4 : d1; bo = sel ? bo4 : bo1;
        break;
      end
      if ((sel ? d4 : d1) !== d0) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2;
    tests++; if ({d1, bo1, busy1, done1} !== 11'd0) begin fails++; $display("FAIL reset_u1 got D=%h Bo=%b busy=%b done=%b want all 0", d1, bo1, busy1, done1); end
    tests++; if ({d4, bo4, busy4, done4} !== 11'd0) begin fails++; $display("FAIL reset_u4 got D=%h Bo=%b busy=%b done=%b want all 0", d4, bo4, busy4, done4); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo; int bc, dc; bit h;
    do_op(1'b0, 8'h5A, 8'h3C, d, bo, bc, dc, h);
    tests++; if (bc !== 8) begin fails++; $display("FAIL basic_busy got %0d want 8", bc); end
    tests++; if (dc !== 9) begin fails++; $display("FAIL basic_done_cycle got %0d want 9", dc); end
    tests++; if ({d, bo} !== {8'h1E, 1'b0}) begin fails++; $display("FAIL basic_result got D=%h Bo=%b want D=1e Bo=0", d, bo); end
    tests++; if (!h) begin fails++; $display("FAIL basic_hold got changed want held during run"); end
    @(negedge clk);
    tests++; if ({done1, busy1} !== 2'b00) begin fails++; $display("FAIL basic_pulse got done=%b busy=%b want 0 0", done1, busy1); end
  endtask

  task automatic test_borrow();
    logic [7:0] d; logic bo; int bc, dc; bit h;
    do_op(1'b0, 8'h00, 8'h01, d, bo, bc, dc, h);
    tests++; if ({d, bo} !== {exp_d(8'h00, 8'h01), 1'b1}) begin fails++; $display("FAIL borrow_result got D=%h Bo=%b want D=%h Bo=1", d, bo, exp_d(8'h00, 8'h01)); end
  endtask

  task automatic test_digit4();
    logic [7:0] d; logic bo; int bc, dc; bit h;
    do_op(1'b1, 8'h80, 8'h01, d, bo, bc, dc, h);
    tests++; if (bc !== 2) begin fails++; $display("FAIL d4_busy got %0d want 2", bc); end
    tests++; if (dc !== 3) begin fails++; $display("FAIL d4_done_cycle got %0d want 3", dc); end
    tests++; if ({d, bo} !== {8'h7F, 1'b0}) begin fails++; $display("FAIL d4_result got D=%h Bo=%b want D=7f Bo=0", d, bo); end
  endtask

  task automatic test_random();
    logic [7:0] a, b, d; logic bo; int bc, dc; bit h;
    for (int n = 0; n < 24; n++) begin
      bit sel = n[0];
      a = 8'($urandom); b = (n % 5 == 0) ? a : 8'($urandom);
      do_op(sel, a, b, d, bo, bc, dc, h);
      tests++;
      if ({d, bo} !== {exp_d(a, b), a < b} || bc !== (sel ? 2 : 8) || dc !== (sel ? 3 : 9) || !h) begin
        fails++;
        $display("FAIL random_%0d sel=%0d A=%h B=%h got D=%h Bo=%b busy=%0d done=%0d held=%0d want D=%h Bo=%b busy=%0d done=%0d held=1",
                 n, sel, a, b, d, bo, bc, dc, h, exp_d(a, b), a < b, sel ? 2 : 8, sel ? 3 : 9);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit seen;
    @(negedge clk); s1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF;
    @(negedge clk); s1 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (done1) seen = 1'b1; else @(negedge clk);
    end
    tests++; if (!seen) begin fails++; $display("FAIL b2b_first_done got none want done"); return; end
    tests++; if ({d1, bo1} !== {8'h00, 1'b0}) begin fails++; $display("FAIL b2b_first got D=%h Bo=%b want D=00 Bo=0", d1, bo1); end
    s1 = 1'b1; a1 = 8'h10; b1 = 8'h20;
    @(negedge clk); s1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
    tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL b2b_no_gap got busy=%b want 1", busy1); end
    bc = 0; seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (done1) seen = 1'b1; else begin if (busy1) bc++; @(negedge clk); end
    end
    tests++; if (bc !== 8 || !seen) begin fails++; $display("FAIL b2b_second_timing got busy=%0d done_seen=%0d want 8 1", bc, seen); end
    tests++; if ({d1, bo1} !== {exp_d(8'h10, 8'h20), 1'b1}) begin fails++; $display("FAIL b2b_second got D=%h Bo=%b want D=%h Bo=1", d1, bo1, exp_d(8'h10, 8'h20)); end
  endtask

  task automatic test_ignore_start();
    int dc;
    @(negedge clk); s1 = 1'b1; a1 = 8'h9C; b1 = 8'h35;
    @(negedge clk); s1 = 1'b0;
    repeat (2) @(negedge clk);
    s1 = 1'b1; a1 = 8'h11; b1 = 8'hEE;
    @(negedge clk); s1 = 1'b0;
    dc = -1;
    for (int c = 4; c <= 30; c++) begin
      if (done1) begin dc = c; break; end
      @(negedge clk);
    end
    tests++; if (dc !== 9) begin fails++; $display("FAIL ignore_timing got done cycle %0d want 9", dc); end
    tests++; if ({d1, bo1} !== {8'h67, 1'b0}) begin fails++; $display("FAIL ignore_result got D=%h Bo=%b want D=67 Bo=0", d1, bo1); end
    @(negedge clk);
    tests++; if ({busy1, done1} !== 2'b00) begin fails++; $display("FAIL ignore_idle got busy=%b done=%b want 0 0", busy1, done1); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] d; logic bo; int bc, dc; bit h, saw;
    @(negedge clk); s1 = 1'b1; a1 = 8'h33; b1 = 8'h11;
    @(negedge clk); s1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if ({d1, bo1, busy1, done1} !== 11'd0) begin fails++; $display("FAIL midrst_outputs got D=%h Bo=%b busy=%b done=%b want all 0", d1, bo1, busy1, done1); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin @(negedge clk); if (done1 || busy1) saw = 1'b1; end
    tests++; if (saw) begin fails++; $display("FAIL midrst_no_done got activity want none"); end
    do_op(1'b0, 8'hC3, 8'h3C, d, bo, bc, dc, h);
    tests++; if ({d, bo} !== {8'h87, 1'b0} || bc !== 8 || dc !== 9) begin fails++; $display("FAIL midrst_after got D=%h Bo=%b busy=%0d done=%0d want D=87 Bo=0 busy=8 done=9", d, bo, bc, dc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_digit4();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
